// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - frame sequencer for the 16-point FFT datapath (ser2par -> fft_core -> par2ser)
//
// Schedules one frame at a time: FILL accepts BEATS input beats into ser2par,
// WAIT issues core_start and times CORE_LAT cycles of core latency, and DRAIN
// streams BEATS output beats from par2ser under out_ready backpressure.
//
// Optional feature macro: FFT_SEQ_CTRL_SOP_CHECK_EN
//   defined   : in_sop checked in FILL; stray beats dropped, early SOP restarts the frame, sop_err pulses
//   undefined : in_sop ignored, sop_err tied 0, frames delimited by beat count only
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   in_valid, in_sop, in_ready     upstream beat handshake
//   s2p_we, s2p_idx                ser2par write strobe and beat slot
//   core_start                     one-cycle pulse, fft_core inputs complete
//   p2s_load, p2s_idx              par2ser capture pulse and presented beat slot
//   out_valid, out_sop, out_eop    output beat qualifiers
//   out_ready                      downstream accepts the output beat
//   busy                           frame in progress
//   frame_cnt                      completed (drained) frames, wraps
//   sop_err                        one-cycle framing-error pulse

module fft_seq_ctrl #(
    parameter int BEATS    = 8,
    parameter int CORE_LAT = 3,
    parameter int FCNT_W   = 16,
    localparam int CNT_W   = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sop,
    output logic              in_ready,
    output logic              s2p_we,
    output logic [CNT_W-1:0]  s2p_idx,
    output logic              core_start,
    output logic              p2s_load,
    output logic [CNT_W-1:0]  p2s_idx,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              sop_err
);

    localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              core_start_q, core_start_d;
    logic              p2s_load_q, p2s_load_d;
    logic              sop_err_q, sop_err_d;

`ifndef FFT_SEQ_CTRL_SOP_CHECK_EN
    logic              sop_unused;
    assign sop_unused = in_sop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            lat_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            core_start_q <= 1'b0;
            p2s_load_q   <= 1'b0;
            sop_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            core_start_q <= core_start_d;
            p2s_load_q   <= p2s_load_d;
            sop_err_q    <= sop_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        core_start_d = 1'b0;
        p2s_load_d   = 1'b0;
        sop_err_d    = 1'b0;
        in_ready     = 1'b0;
        s2p_we       = 1'b0;
        s2p_idx      = wr_cnt_q;
        out_valid    = 1'b0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;

        case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef FFT_SEQ_CTRL_SOP_CHECK_EN
                    if (wr_cnt_q == '0 && !in_sop) begin
                        // Stray beat before any SOP: consume it, write nothing.
                        sop_err_d = 1'b1;
                    end else if (wr_cnt_q != '0 && in_sop) begin
                        // New frame began early: abandon partial frame, this beat is slot 0.
                        s2p_we    = 1'b1;
                        s2p_idx   = '0;
                        wr_cnt_d  = CNT_W'(1);
                        sop_err_d = 1'b1;
                    end else
`endif
                    begin
                        s2p_we = 1'b1;
                        if (wr_cnt_q == CNT_W'(BEATS - 1)) begin
                            wr_cnt_d     = '0;
                            lat_cnt_d    = '0;
                            state_d      = S_WAIT;
                            core_start_d = 1'b1;
                            // Single-cycle core latency loads par2ser in the first WAIT cycle.
                            p2s_load_d   = (CORE_LAT == 1);
                        end else begin
                            wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end

            S_WAIT: begin
                if (lat_cnt_q == LAT_W'(CORE_LAT - 1)) begin
                    state_d  = S_DRAIN;
                    rd_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    // Pulse lands in the cycle where lat_cnt reaches CORE_LAT-1.
                    if (lat_cnt_q + LAT_W'(1) == LAT_W'(CORE_LAT - 1)) begin
                        p2s_load_d = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                out_valid = 1'b1;
                out_sop   = (rd_cnt_q == '0);
                out_eop   = (rd_cnt_q == CNT_W'(BEATS - 1));
                if (out_ready) begin
                    if (rd_cnt_q == CNT_W'(BEATS - 1)) begin
                        rd_cnt_d    = '0;
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                        state_d     = S_FILL;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    assign core_start = core_start_q;
    assign p2s_load   = p2s_load_q;
    assign p2s_idx    = rd_cnt_q;
    assign busy       = (state_q != S_FILL) || (wr_cnt_q != '0);
    assign frame_cnt  = frame_cnt_q;
`ifdef FFT_SEQ_CTRL_SOP_CHECK_EN
    assign sop_err    = sop_err_q;
`else
    assign sop_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - directed self-checking bench for fft_seq_ctrl (BEATS=8, CORE_LAT=3, FCNT_W=2)

module tb_fft_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sop;
    logic       in_ready;
    logic       s2p_we;
    logic [2:0] s2p_idx;
    logic       core_start;
    logic       p2s_load;
    logic [2:0] p2s_idx;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       out_ready;
    logic       busy;
    logic [1:0] frame_cnt;
    logic       sop_err;

    int checks;
    int failures;

    fft_seq_ctrl #(
        .BEATS    (8),
        .CORE_LAT (3),
        .FCNT_W   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_ready   (in_ready),
        .s2p_we     (s2p_we),
        .s2p_idx    (s2p_idx),
        .core_start (core_start),
        .p2s_load   (p2s_load),
        .p2s_idx    (p2s_idx),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .sop_err    (sop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int n, input bit first_sop);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sop   = first_sop && (i == 0);
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic drain(output int n, output bit done);
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid) n++;
            if (out_valid && out_eop) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_sop, out_eop, core_start, p2s_load, busy, sop_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000000",
                     {out_valid, out_sop, out_eop, core_start, p2s_load, busy, sop_err});
        end
        checks++;
        if (frame_cnt !== 2'd0) begin
            failures++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt);
        end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [5:0] obs, exp_v;
        for (int c = 0; c < 21; c++) begin
            in_valid  = (c < 8);
            in_sop    = (c == 0);
            out_ready = 1'b1;
            @(negedge clk);
            obs   = {s2p_we, core_start, p2s_load, out_valid, out_sop, out_eop};
            exp_v = {c < 8, c == 8, c == 10, c >= 11 && c <= 18, c == 11, c == 18};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL basic_cycle%0d we/start/load/ov/sop/eop got=%b want=%b", c, obs, exp_v);
            end
            if (c < 8) begin
                checks++;
                if (s2p_idx !== 3'(c)) begin
                    failures++; $display("FAIL basic_s2p_idx cycle%0d got=%0d want=%0d", c, s2p_idx, c);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        checks++;
        if (frame_cnt !== 2'd1) begin
            failures++; $display("FAIL basic_frame_cnt got=%0d want=1", frame_cnt);
        end
    endtask

    task automatic test_bubbles();
        int  k;
        int  n;
        bit  done;
        bit  started;
        k = 0;
        started = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            in_valid = (cyc % 2 == 0);
            in_sop   = (cyc == 0);
            @(negedge clk);
            if (s2p_we) begin
                checks++;
                if (s2p_idx !== 3'(k)) begin
                    failures++; $display("FAIL bubble_s2p_idx got=%0d want=%0d", s2p_idx, k);
                end
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        @(negedge clk);
        started = core_start;
        checks++;
        if (k != 8 || started !== 1'b1) begin
            failures++; $display("FAIL bubble_core_start beats=%0d start=%b want beats=8 start=1", k, started);
        end
        tick();
        drain(n, done);
        checks++;
        if (!done || n != 8 || frame_cnt !== 2'd2) begin
            failures++;
            $display("FAIL bubble_drain done=%b beats=%0d frame_cnt=%0d want done=1 beats=8 frame_cnt=2", done, n, frame_cnt);
        end
    endtask

    task automatic test_stall();
        bit found;
        int n;
        bit done;
        found = 1'b0;
        send_beats(8, 1'b1);
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && p2s_idx == 3'd3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL stall_reach_idx3 got=timeout want=p2s_idx 3");
        end
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, p2s_idx} !== {1'b1, 1'b0, 3'd3}) begin
                failures++;
                $display("FAIL stall_hold%0d ov=%b ir=%b idx=%0d want ov=1 ir=0 idx=3", s, out_valid, in_ready, p2s_idx);
            end
        end
        out_ready = 1'b1;
        tick();
        drain(n, done);
        checks++;
        if (!done || n != 4 || frame_cnt !== 2'd3) begin
            failures++;
            $display("FAIL stall_drain done=%b beats=%0d frame_cnt=%0d want done=1 beats=4 frame_cnt=3", done, n, frame_cnt);
        end
    endtask

    task automatic test_midreset();
        bit pulse_seen;
        int n;
        bit done;
        pulse_seen = 1'b0;
        send_beats(5, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || s2p_idx !== 3'd5) begin
            failures++; $display("FAIL midreset_pre busy=%b idx=%0d want busy=1 idx=5", busy, s2p_idx);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, core_start, p2s_load, s2p_idx, frame_cnt} !== 9'b0) begin
            failures++;
            $display("FAIL midreset_clear busy=%b ov=%b start=%b load=%b idx=%0d fcnt=%0d want all 0",
                     busy, out_valid, core_start, p2s_load, s2p_idx, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (core_start || p2s_load) pulse_seen = 1'b1;
            tick();
        end
        checks++;
        if (pulse_seen) begin
            failures++; $display("FAIL midreset_no_pulse got=pulse want=none");
        end
        in_valid = 1'b1;
        in_sop   = 1'b1;
        @(negedge clk);
        checks++;
        if (s2p_we !== 1'b1 || s2p_idx !== 3'd0) begin
            failures++; $display("FAIL midreset_restart we=%b idx=%0d want we=1 idx=0", s2p_we, s2p_idx);
        end
        tick();
        send_beats(7, 1'b0);
        drain(n, done);
        checks++;
        if (!done || n != 8 || frame_cnt !== 2'd1) begin
            failures++;
            $display("FAIL midreset_frame done=%b beats=%0d frame_cnt=%0d want done=1 beats=8 frame_cnt=1", done, n, frame_cnt);
        end
    endtask

    task automatic test_sop();
        bit err_seen;
        int n;
        bit done;
        err_seen = 1'b0;
`ifdef FFT_SEQ_CTRL_SOP_CHECK_EN
        in_valid = 1'b1;
        in_sop   = 1'b0;
        @(negedge clk);
        checks++;
        if (s2p_we !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL sop_drop we=%b ir=%b want we=0 ir=1", s2p_we, in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sop_err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL sop_drop_err err=%b busy=%b want err=1 busy=0", sop_err, busy);
        end
        tick();
        send_beats(4, 1'b1);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        @(negedge clk);
        checks++;
        if (s2p_we !== 1'b1 || s2p_idx !== 3'd0) begin
            failures++; $display("FAIL sop_restart we=%b idx=%0d want we=1 idx=0", s2p_we, s2p_idx);
        end
        tick();
        in_sop = 1'b0;
        @(negedge clk);
        checks++;
        if (sop_err !== 1'b1 || s2p_idx !== 3'd1) begin
            failures++; $display("FAIL sop_restart_err err=%b idx=%0d want err=1 idx=1", sop_err, s2p_idx);
        end
        tick();
        send_beats(7, 1'b0);
`else
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 4);
            @(negedge clk);
            if (sop_err) err_seen = 1'b1;
            if (i == 0 || i == 4) begin
                checks++;
                if (s2p_we !== 1'b1 || s2p_idx !== 3'(i)) begin
                    failures++; $display("FAIL sop_ignored beat%0d we=%b idx=%0d want we=1 idx=%0d", i, s2p_we, s2p_idx, i);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        checks++;
        if (err_seen) begin
            failures++; $display("FAIL sop_err_tied got=1 want=0");
        end
`endif
        drain(n, done);
        checks++;
        if (!done || n != 8 || frame_cnt !== 2'd2) begin
            failures++;
            $display("FAIL sop_frame done=%b beats=%0d frame_cnt=%0d want done=1 beats=8 frame_cnt=2", done, n, frame_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_cnt;
        int n;
        bit done;
        for (int f = 0; f < 3; f++) begin
            exp_cnt = 2'((3 + f) % 4);
            send_beats(8, 1'b1);
            drain(n, done);
            checks++;
            if (!done || frame_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL wrap_frame%0d done=%b frame_cnt=%0d want done=1 frame_cnt=%0d", f, done, frame_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_bubbles();
        test_stall();
        test_midreset();
        test_sop();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
